// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the ctrl_seq fetch/execute sequencer.
// The instruction fields decoded here select the bus drivers and load strobes.
package ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_t;

  localparam logic [1:0] KIND_MOVE = 2'd0;
  localparam logic [1:0] KIND_JUMP = 2'd1;
  localparam logic [1:0] KIND_NOP  = 2'd2;
  localparam logic [1:0] KIND_HALT = 2'd3;

  localparam logic [1:0] SRC_A   = 2'd0;
  localparam logic [1:0] SRC_B   = 2'd1;
  localparam logic [1:0] SRC_IMM = 2'd2;
  localparam logic [1:0] SRC_ALU = 2'd3;

  localparam logic [1:0] DST_A    = 2'd0;
  localparam logic [1:0] DST_B    = 2'd1;
  localparam logic [1:0] DST_X    = 2'd2;
  localparam logic [1:0] DST_NONE = 2'd3;

  localparam logic [1:0] COND_ALWAYS = 2'd0;
  localparam logic [1:0] COND_Z      = 2'd1;
  localparam logic [1:0] COND_C      = 2'd2;
  localparam logic [1:0] COND_NZ     = 2'd3;

  typedef struct packed {
    logic assert_rom;
    logic assert_a;
    logic assert_b;
    logic assert_bar_e;
    logic do_subtract;
    logic load_a;
    logic load_b;
    logic load_x;
    logic halted;
  } ctrl_t;

  // Nothing drives the bus and nothing loads; the ALU drive is active-low.
  localparam ctrl_t CTRL_IDLE = ctrl_t'(9'b0_0_0_1_0_0_0_0_0);

  function automatic logic cond_met(input logic [1:0] cc, input logic a_is_zero,
                                    input logic flag_carry);
    case (cc)
      COND_ALWAYS: cond_met = 1'b1;
      COND_Z:      cond_met = a_is_zero;
      COND_C:      cond_met = flag_carry;
      default:     cond_met = !a_is_zero;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of state + IR + ALU flags into the control vector,
// the PC update select and the next state.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [7:0]  ir,
  input  logic        a_is_zero,
  input  logic        flag_carry,
  output ctrl_t       ctrl,
  output pc_sel_t     pc_sel,
  output state_t      next_state
);

  logic [1:0] kind;
  logic [1:0] src;
  logic [1:0] dst;
  logic       unused_bit;

  assign kind       = ir[7:6];
  assign src        = ir[5:4];
  assign dst        = ir[3:2];
  assign unused_bit = ir[1];

  always_comb begin
    ctrl       = CTRL_IDLE;
    pc_sel     = PC_HOLD;
    next_state = state;
    case (state)
      FETCH: begin
        ctrl.assert_rom = 1'b1;
        pc_sel          = PC_INC;
        next_state      = EXEC;
      end
      EXEC: begin
        next_state = FETCH;
        case (kind)
          KIND_MOVE: begin
            case (src)
              SRC_A:   ctrl.assert_a = 1'b1;
              SRC_B:   ctrl.assert_b = 1'b1;
              SRC_IMM: begin
                ctrl.assert_rom = 1'b1;
                pc_sel          = PC_INC;
              end
              default: begin
                ctrl.assert_bar_e = 1'b0;
                ctrl.do_subtract  = ir[0];
              end
            endcase
            case (dst)
              DST_A:   ctrl.load_a = 1'b1;
              DST_B:   ctrl.load_b = 1'b1;
              DST_X:   ctrl.load_x = 1'b1;
              default: ;
            endcase
          end
          KIND_JUMP: begin
            // Operand byte is on the bus either way; a miss just steps over it.
            ctrl.assert_rom = 1'b1;
            pc_sel = cond_met(src, a_is_zero, flag_carry) ? PC_LOAD : PC_INC;
          end
          KIND_NOP: ;
          default: next_state = HALT;
        endcase
      end
      HALT: ctrl.halted = 1'b1;
      default: next_state = FETCH;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Fetch/execute sequencer in front of the 8-bit ALU: holds PC, IR and state,
// and forces every control output idle while reset is high.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dbus_in,
  input  logic       aIsZero,
  input  logic       flagCarry,
  output logic [7:0] romAddr,
  output logic       assertRom,
  output logic       assertA,
  output logic       assertB,
  output logic       assertBarE,
  output logic       doSubtract,
  output logic       loadA,
  output logic       loadB,
  output logic       loadX,
  output logic       halted
);

  state_t     state_reg;
  state_t     state_next;
  logic [7:0] pc_reg;
  logic [7:0] ir_reg;
  ctrl_t      ctrl_dec;
  ctrl_t      ctrl_out;
  pc_sel_t    pc_sel;

  ctrl_decode u_decode (
    .state      (state_reg),
    .ir         (ir_reg),
    .a_is_zero  (aIsZero),
    .flag_carry (flagCarry),
    .ctrl       (ctrl_dec),
    .pc_sel     (pc_sel),
    .next_state (state_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      ir_reg    <= 8'h00;
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
      if (state_reg == FETCH) ir_reg <= dbus_in;
      case (pc_sel)
        PC_INC:  pc_reg <= pc_reg + 8'd1;
        PC_LOAD: pc_reg <= dbus_in;
        default: ;
      endcase
    end
  end

  // Reset overrides the decode so an aborted instruction never strobes a load.
  assign ctrl_out   = reset ? CTRL_IDLE : ctrl_dec;

  assign romAddr    = pc_reg;
  assign assertRom  = ctrl_out.assert_rom;
  assign assertA    = ctrl_out.assert_a;
  assign assertB    = ctrl_out.assert_b;
  assign assertBarE = ctrl_out.assert_bar_e;
  assign doSubtract = ctrl_out.do_subtract;
  assign loadA      = ctrl_out.load_a;
  assign loadB      = ctrl_out.load_b;
  assign loadX      = ctrl_out.load_x;
  assign halted     = ctrl_out.halted;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed, table-driven bench for ctrl_seq with a ROM model on the data bus.
// Control vectors are compared as {rom,a,b,barE,sub,ldA,ldB,ldX,halted}.
module tb_ctrl_seq;

  typedef struct {
    logic       rst;
    logic       z;
    logic       c;
    logic [7:0] addr;
    logic [8:0] ctl;
  } vec_t;

  localparam logic [8:0] C_IDLE = 9'b0_0_0_1_0_0_0_0_0;
  localparam logic [8:0] C_ROM  = 9'b1_0_0_1_0_0_0_0_0;
  localparam logic [8:0] C_HALT = 9'b0_0_0_1_0_0_0_0_1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_is_zero = 1'b0;
  logic       flag_carry = 1'b0;
  logic [7:0] rom [256];

  logic [7:0] dbus0, addr0, dbus1, addr1;
  logic       rom0, a0, b0, bare0, sub0, la0, lb0, lx0, h0;
  logic       rom1, a1, b1, bare1, sub1, la1, lb1, lx1, h1;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  assign dbus0 = rom0 ? rom[addr0] : 8'hEE;
  assign dbus1 = rom1 ? rom[addr1] : 8'hEE;

  ctrl_seq dut0 (
    .clk(clk), .reset(reset), .dbus_in(dbus0), .aIsZero(a_is_zero),
    .flagCarry(flag_carry), .romAddr(addr0), .assertRom(rom0), .assertA(a0),
    .assertB(b0), .assertBarE(bare0), .doSubtract(sub0), .loadA(la0),
    .loadB(lb0), .loadX(lx0), .halted(h0)
  );

  ctrl_seq #(.RESET_PC(8'hFE)) dut1 (
    .clk(clk), .reset(reset), .dbus_in(dbus1), .aIsZero(a_is_zero),
    .flagCarry(flag_carry), .romAddr(addr1), .assertRom(rom1), .assertA(a1),
    .assertB(b1), .assertBarE(bare1), .doSubtract(sub1), .loadA(la1),
    .loadB(lb1), .loadX(lx1), .halted(h1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic z, input logic c,
                     input logic [7:0] addr, input logic [8:0] ctl);
    vec_t v;
    v.rst = rst; v.z = z; v.c = c; v.addr = addr; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  function automatic logic [8:0] ctl0();
    return {rom0, a0, b0, bare0, sub0, la0, lb0, lx0, h0};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h80;
    rom[8'h00] = 8'h20; rom[8'h01] = 8'h05;   // MOVE IMM->A, 05
    rom[8'h02] = 8'h34;                       // MOVE ALU->B
    rom[8'h03] = 8'h35;                       // MOVE ALU->B, subtract
    rom[8'h04] = 8'h50; rom[8'h05] = 8'h40;   // JUMP Z 40
    rom[8'h40] = 8'h50; rom[8'h41] = 8'h44;   // JUMP Z 44
    rom[8'h42] = 8'h60; rom[8'h43] = 8'h48;   // JUMP C 48
    rom[8'h48] = 8'h70; rom[8'h49] = 8'h10;   // JUMP NZ 10
    rom[8'h4A] = 8'h08;                       // MOVE A->X
    rom[8'h4B] = 8'h80;                       // NOP
    rom[8'h4C] = 8'h1C;                       // MOVE B->none
    rom[8'h4D] = 8'hC0;                       // HALT
    rom[8'hFE] = 8'h20; rom[8'hFF] = 8'h99;   // wrap program for dut1

    add(1, 0, 0, 8'h00, C_IDLE);
    add(0, 0, 0, 8'h00, C_ROM);
    add(0, 0, 0, 8'h01, 9'b1_0_0_1_0_1_0_0_0);
    add(0, 0, 0, 8'h02, C_ROM);
    add(0, 0, 0, 8'h03, 9'b0_0_0_0_0_0_1_0_0);
    add(0, 0, 0, 8'h03, C_ROM);
    add(0, 0, 0, 8'h04, 9'b0_0_0_0_1_0_1_0_0);
    add(0, 0, 0, 8'h04, C_ROM);
    add(0, 1, 0, 8'h05, C_ROM);
    add(0, 0, 0, 8'h40, C_ROM);
    add(0, 0, 0, 8'h41, C_ROM);
    add(0, 0, 0, 8'h42, C_ROM);
    add(0, 0, 1, 8'h43, C_ROM);
    add(0, 0, 0, 8'h48, C_ROM);
    add(0, 1, 0, 8'h49, C_ROM);
    add(0, 0, 0, 8'h4A, C_ROM);
    add(0, 0, 0, 8'h4B, 9'b0_1_0_1_0_0_0_1_0);
    add(0, 0, 0, 8'h4B, C_ROM);
    add(0, 0, 0, 8'h4C, C_IDLE);
    add(0, 0, 0, 8'h4C, C_ROM);
    add(0, 0, 0, 8'h4D, 9'b0_0_1_1_0_0_0_0_0);
    add(0, 0, 0, 8'h4D, C_ROM);
    add(0, 0, 0, 8'h4E, C_IDLE);
    for (int i = 0; i < 10; i++) add(0, i[0], 1, 8'h4E, C_HALT);
    add(1, 0, 0, 8'h4E, C_IDLE);
    add(0, 0, 0, 8'h00, C_ROM);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      #1;
      reset = vecs[i].rst; a_is_zero = vecs[i].z; flag_carry = vecs[i].c;
      @(negedge clk);
      check($sformatf("row%0d_addr", i), 32'(addr0), 32'(vecs[i].addr));
      check($sformatf("row%0d_ctl", i), 32'(ctl0()), 32'(vecs[i].ctl));
      check($sformatf("row%0d_bus_excl", i),
            32'($countones({rom0, a0, b0, ~bare0}) <= 1), 32'd1);
      check($sformatf("row%0d_load_excl", i),
            32'($countones({la0, lb0, lx0}) <= 1), 32'd1);
      $display("row %0d: rst=%b z=%b c=%b addr=%h ctl=%b", i, vecs[i].rst,
               vecs[i].z, vecs[i].c, addr0, ctl0());
      @(posedge clk);
    end

    // Reset arriving during the EXEC of MOVE A->X must suppress loadX.
    #1 reset = 1'b1; a_is_zero = 1'b0; flag_carry = 1'b0; rom[8'h00] = 8'h08;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_fetch_addr", 32'(addr0), 32'h00);
    check("abort_fetch_rom", 32'(rom0), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("abort_exec_addr", 32'(addr0), 32'h01);
    check("abort_exec_ctl", 32'(ctl0()), 32'(C_IDLE));
    $display("abort: addr=%h ctl=%b", addr0, ctl0());
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_refetch_addr", 32'(addr0), 32'h00);

    // PC wrap on the immediate increment, observed on the RESET_PC=FE instance.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("wrap_fetch_addr", 32'(addr1), 32'hFE);
    check("wrap_fetch_rom", 32'(rom1), 32'd1);
    @(negedge clk);
    check("wrap_exec_addr", 32'(addr1), 32'hFF);
    check("wrap_exec_ctl", 32'({rom1, a1, b1, bare1, sub1, la1, lb1, lx1, h1}),
          32'(9'b1_0_0_1_0_1_0_0_0));
    @(negedge clk);
    check("wrap_next_addr", 32'(addr1), 32'h00);
    check("wrap_next_rom", 32'(rom1), 32'd1);
    $display("wrap: addr=%h rom=%b", addr1, rom1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
